// File: rtl/mm_bram_ctrl_pkg.sv
// mm_bram_ctrl_pkg: shared types and constants for the parallel matrix-multiply BRAM controller
//   mm_ctrl_state_t : controller FSM states
//   PERF_WIDTH      : width of the optional pass cycle counter (MM_CTRL_PERF_CNT_EN)
package mm_bram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mm_ctrl_state_t;
    localparam int PERF_WIDTH = 32;
endpackage

// File: rtl/mm_ctrl_delay_line.sv
// mm_ctrl_delay_line: DEPTH-stage shift register with asynchronous clear
//   clk   : clock
//   reset : asynchronous active-high clear of every stage
//   din   : value entering stage 0
//   dout  : value leaving the last stage, DEPTH cycles after it entered
module mm_ctrl_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/mm_bram_parallel_ctrl.sv
// mm_bram_parallel_ctrl: issues source-row reads, aligns datapath strobes to SRAM latency, counts write-backs
//   clk, reset            : clock and asynchronous active-high reset
//   start                 : begin a pass (sampled only in IDLE)
//   busy, done            : pass in progress / one-cycle completion pulse
//   src_rd_en/addr        : source SRAM read port
//   dpath_sum_en/wraddr   : read strobe and row index delayed by SRAM_RD_LAT
//   wb_val                : datapath write-back strobe
//   perf_cycles           : ISSUE+DRAIN cycles of the last pass (only with MM_CTRL_PERF_CNT_EN)
module mm_bram_parallel_ctrl
    import mm_bram_ctrl_pkg::*;
#(
    parameter int ROW_NUM = 32,
    parameter int SRAM_RD_LAT = 1,
    localparam int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1,
    localparam int CNT_WIDTH = $clog2(ROW_NUM + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      src_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0] src_rd_addr,
    output logic                      dpath_sum_en,
    output logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr,
    input  logic                      wb_val
`ifdef MM_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_WIDTH-1:0]     perf_cycles
`endif
);
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ADDR = ROW_ADDR_WIDTH'(ROW_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(ROW_NUM);
    mm_ctrl_state_t            state;
    logic [ROW_ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_WIDTH-1:0]      wb_cnt;
    logic                      pass_start;
    logic                      counting;
    assign pass_start = (state == IDLE) && start;
    assign counting   = (state == ISSUE) || (state == DRAIN);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= ISSUE;
                    rd_addr <= '0;
                end
                // pointer parks on the last row so it never wraps
                ISSUE: if (rd_addr == LAST_ADDR) state <= DRAIN;
                       else rd_addr <= rd_addr + ROW_ADDR_WIDTH'(1);
                DRAIN: if (wb_cnt == CNT_FULL) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
    // write-backs outside a pass are ignored; count saturates at ROW_NUM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wb_cnt <= '0;
        else if (pass_start) wb_cnt <= '0;
        else if (counting && wb_val && wb_cnt != CNT_FULL) wb_cnt <= wb_cnt + CNT_WIDTH'(1);
    end
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign src_rd_en   = state == ISSUE;
    assign src_rd_addr = rd_addr;
    mm_ctrl_delay_line #(
        .WIDTH(1 + ROW_ADDR_WIDTH),
        .DEPTH(SRAM_RD_LAT)
    ) u_dly (
        .clk  (clk),
        .reset(reset),
        .din  ({src_rd_en, src_rd_addr}),
        .dout ({dpath_sum_en, dpath_result_wraddr})
    );
`ifdef MM_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_cycles <= '0;
        else if (pass_start) perf_cycles <= '0;
        else if (counting) perf_cycles <= perf_cycles + PERF_WIDTH'(1);
    end
`endif
endmodule

// File: tb/tb_mm_bram_parallel_ctrl.sv
// tb_mm_bram_parallel_ctrl: checks two controllers (read latency 1 and 3, ROW_NUM=4) against a pass-level model
module tb_mm_bram_parallel_ctrl;
    localparam int ROW = 4;
    localparam int AW = 2;
    localparam int MAXC = 4096;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [1:0] wb = '0;
    logic [1:0] busy, done, rd_en, sum_en;
    logic [AW-1:0] rd_addr [2];
    logic [AW-1:0] wraddr [2];
    logic [31:0] perf [2];
    int lat [2] = '{1, 3};
    bit m_busy [2];
    bit m_done [2];
    int m_k [2];
    int m_wb [2];
    int m_addr [2];
    int m_perf [2];
    bit h_en [2][MAXC];
    int h_addr [2][MAXC];
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm_bram_parallel_ctrl #(.ROW_NUM(ROW), .SRAM_RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
        .src_rd_en(rd_en[0]), .src_rd_addr(rd_addr[0]), .dpath_sum_en(sum_en[0]),
        .dpath_result_wraddr(wraddr[0]), .wb_val(wb[0])
`ifdef MM_CTRL_PERF_CNT_EN
        , .perf_cycles(perf[0])
`endif
    );
    mm_bram_parallel_ctrl #(.ROW_NUM(ROW), .SRAM_RD_LAT(3)) u_b (
        .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
        .src_rd_en(rd_en[1]), .src_rd_addr(rd_addr[1]), .dpath_sum_en(sum_en[1]),
        .dpath_result_wraddr(wraddr[1]), .wb_val(wb[1])
`ifdef MM_CTRL_PERF_CNT_EN
        , .perf_cycles(perf[1])
`endif
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cycle %0d: observed=%0h expected=%0h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_k[i] = 0; m_wb[i] = 0; m_addr[i] = 0; m_perf[i] = 0;
        end
    endtask

    // mode: 0 no write-back, 1 echo of dpath_sum_en 3 cycles later, 2 random, 3 always
    task automatic step(input bit s, input int mode);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit e_en;
            bit d_en;
            int d_addr;
            e_en = m_busy[i] && !m_done[i] && m_k[i] <= ROW;
            h_en[i][cyc] = e_en;
            h_addr[i][cyc] = m_addr[i];
            d_en = (cyc >= lat[i]) ? h_en[i][cyc-lat[i]] : 1'b0;
            d_addr = (cyc >= lat[i]) ? h_addr[i][cyc-lat[i]] : 0;
            chk("busy", i, 32'(busy[i]), 32'(m_busy[i]));
            chk("done", i, 32'(done[i]), 32'(m_done[i]));
            chk("src_rd_en", i, 32'(rd_en[i]), 32'(e_en));
            chk("src_rd_addr", i, 32'(rd_addr[i]), 32'(m_addr[i]));
            chk("dpath_sum_en", i, 32'(sum_en[i]), 32'(d_en));
            chk("dpath_result_wraddr", i, 32'(wraddr[i]), 32'(d_addr));
`ifdef MM_CTRL_PERF_CNT_EN
            chk("perf_cycles", i, perf[i], 32'(m_perf[i]));
`endif
        end
        start = s;
        for (int i = 0; i < 2; i++)
            wb[i] = (mode == 0) ? 1'b0 :
                    (mode == 1) ? ((cyc >= lat[i] + 3) ? h_en[i][cyc-lat[i]-3] : 1'b0) :
                    (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!m_busy[i]) begin
                if (s) begin
                    m_busy[i] = 1; m_k[i] = 1; m_wb[i] = 0; m_addr[i] = 0; m_perf[i] = 0;
                end
            end else if (m_done[i]) begin
                m_busy[i] = 0; m_done[i] = 0;
            end else begin
                m_perf[i]++;
                if (m_k[i] > ROW && m_wb[i] == ROW) m_done[i] = 1;
                if (wb[i] && m_wb[i] < ROW) m_wb[i]++;
                if (m_k[i] < ROW) m_addr[i] = m_k[i];
                m_k[i]++;
            end
        end
        if (cyc < MAXC - 1) cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        wb = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, 32'(busy[i]), 0);
            chk("reset_done", i, 32'(done[i]), 0);
            chk("reset_src_rd_en", i, 32'(rd_en[i]), 0);
            chk("reset_src_rd_addr", i, 32'(rd_addr[i]), 0);
            chk("reset_dpath_sum_en", i, 32'(sum_en[i]), 0);
            chk("reset_dpath_result_wraddr", i, 32'(wraddr[i]), 0);
`ifdef MM_CTRL_PERF_CNT_EN
            chk("reset_perf_cycles", i, perf[i], 0);
`endif
        end
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c <= cyc; c++) begin
                h_en[i][c] = 1'b0;
                h_addr[i][c] = 0;
            end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        model_clear();
        do_reset();
        // single pass with write-backs echoed from the datapath strobe
        step(1'b1, 1);
        repeat (14) step(1'b0, 1);
        // start held high: pulses in every busy state are ignored, next pass after one IDLE
        repeat (30) step(1'b1, 1);
        repeat (12) step(1'b0, 1);
        // reset in DRAIN after two write-backs, then a fresh pass
        step(1'b1, 0);
        repeat (4) step(1'b0, 0);
        repeat (2) step(1'b0, 3);
        step(1'b0, 0);
        do_reset();
        step(1'b1, 1);
        repeat (16) step(1'b0, 1);
        // write-backs in IDLE are ignored; six write-backs saturate the count
        repeat (3) step(1'b0, 3);
        step(1'b1, 3);
        repeat (6) step(1'b0, 3);
        repeat (8) step(1'b0, 0);
        // random traffic with occasional resets
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step($urandom_range(0, 7) == 0, 2);
        end
        repeat (12) step(1'b0, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
